// File: rtl/vicii_bus_responder.sv
// vicii_bus_responder: shares 64 KB RAM between VIC-II fetches and the CPU.
// Maps VIC addresses through the CIA2 bank bits and overlays the character ROM.
module vicii_bus_responder #(
    parameter int BA_LEAD = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] vic_ao,
    input  logic        ba_in,
    input  logic [1:0]  bank,
    output logic [7:0]  vic_di,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    input  logic        cpu_req,
    output logic [7:0]  cpu_di,
    output logic        cpu_ack,
    output logic        cpu_rdy,
    output logic        cpu_aec,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_do,
    input  logic [7:0]  mem_di,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_di
);
    localparam int CW = $clog2(2 * BA_LEAD);
    localparam logic [CW-1:0] LEAD = CW'(2 * BA_LEAD - 1);

    typedef enum logic [1:0] {CPU, WARN, VIC} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          phase, sel_rom, vic_slot, rom_hit, grant;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CPU: begin
                if (ba_in) begin
                    state_nx = WARN;
                    cnt_nx   = LEAD;
                end
            end
            WARN: begin
                if (!ba_in) begin
                    state_nx = CPU;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx = VIC;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            VIC: state_nx = ba_in ? VIC : CPU;
            default: begin
                state_nx = CPU;
                cnt_nx   = '0;
            end
        endcase
    end

    assign vic_slot = !phase || state == VIC;
    assign rom_hit  = !bank[0] && vic_ao[13:12] == 2'b01;
    // A read racing the WARN entry loses; writes may still complete during WARN.
    assign grant    = !vic_slot && cpu_req && (cpu_we || (state == CPU && !ba_in));
    assign mem_we   = !reset && grant && cpu_we;
    assign mem_addr = vic_slot ? {bank, vic_ao} : cpu_addr;
    assign mem_do   = cpu_do;
    assign rom_addr = vic_ao[11:0];
    assign vic_di   = sel_rom ? rom_di : mem_di;
    assign cpu_di   = mem_di;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CPU;
            cnt     <= '0;
            phase   <= 1'b0;
            sel_rom <= 1'b0;
            cpu_ack <= 1'b0;
            cpu_rdy <= 1'b1;
            cpu_aec <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            phase   <= !phase;
            if (vic_slot) sel_rom <= rom_hit;
            cpu_ack <= grant;
            cpu_rdy <= state_nx == CPU;
            cpu_aec <= state_nx != VIC;
        end
    end
endmodule

// File: tb/tb_vicii_bus_responder.sv
// tb_vicii_bus_responder: directed vectors against a RAM/ROM model; expected
// values are queued per cycle and checked by an independent monitor.
module tb_vicii_bus_responder;
    localparam int RDY = 0, AEC = 1, WE = 2, MA = 3, RA = 4, VD = 5, MD = 6, ACK = 7;

    logic        clk = 1'b0, reset = 1'b1;
    logic [13:0] vic_ao;
    logic        ba_in;
    logic [1:0]  bank;
    logic [7:0]  vic_di;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_do;
    logic        cpu_we, cpu_req;
    logic [7:0]  cpu_di;
    logic        cpu_ack, cpu_rdy, cpu_aec;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_do;
    logic [7:0]  mem_di = 8'h00;
    logic [11:0] rom_addr;
    logic [7:0]  rom_di = 8'h00;

    logic [7:0] ram [65536];
    logic [7:0] rom [4096];

    typedef struct { int at; int sig; logic [15:0] val; string name; } exp_t;
    typedef struct { int at; logic chk; logic [7:0] data; } ack_t;
    exp_t exp_q[$];
    ack_t ack_q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;

    vicii_bus_responder #(.BA_LEAD(3)) dut (
        .clk(clk), .reset(reset), .vic_ao(vic_ao), .ba_in(ba_in), .bank(bank),
        .vic_di(vic_di), .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_req(cpu_req), .cpu_di(cpu_di), .cpu_ack(cpu_ack), .cpu_rdy(cpu_rdy),
        .cpu_aec(cpu_aec), .mem_addr(mem_addr), .mem_we(mem_we), .mem_do(mem_do),
        .mem_di(mem_di), .rom_addr(rom_addr), .rom_di(rom_di)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

    always @(posedge clk) begin
        mem_di <= ram[mem_addr];
        rom_di <= rom[rom_addr];
        if (mem_we) ram[mem_addr] <= mem_do;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] sig_val(input int s);
        case (s)
            RDY: return 16'(cpu_rdy);
            AEC: return 16'(cpu_aec);
            WE:  return 16'(mem_we);
            MA:  return mem_addr;
            RA:  return 16'(rom_addr);
            VD:  return 16'(vic_di);
            MD:  return 16'(mem_do);
            ACK: return 16'(cpu_ack);
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_at(input int at, input int s, input logic [15:0] v, input string name);
        exp_q.push_back('{at, s, v, name});
    endtask

    task automatic expect_ack(input int at, input logic chk, input logic [7:0] d);
        ack_q.push_back('{at, chk, d});
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        cpu_req  = r;
        cpu_we   = w;
        cpu_addr = a;
        cpu_do   = d;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].at == cyc) begin
                    check(exp_q[i].name, sig_val(exp_q[i].sig), exp_q[i].val);
                    exp_q.delete(i);
                end
            end
            if (ack_q.size() > 0 && ack_q[0].at == cyc) begin
                check("ack", 16'(cpu_ack), 16'h0001);
                if (ack_q[0].chk) check("ack_data", 16'(cpu_di), 16'(ack_q[0].data));
                void'(ack_q.pop_front());
            end else if (cpu_ack) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack @cyc %0d: got 1, expected 0", cyc);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ba_in  = 1'b0;
        bank   = 2'b01;
        vic_ao = '0;
        cpu(0, 0, 16'h0000, 8'h00);
        for (int i = 0; i < 65536; i++) ram[i] <= i[15:8] ^ i[7:0];
        for (int i = 0; i < 4096; i++) rom[i] <= ~i[7:0];
        ram[16'h47F8] <= 8'h80;
        rom[12'h234]  <= 8'hA5;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // write requested on phase 0 waits for the phase-1 slot
        cpu(1, 1, 16'h1000, 8'h77);
        expect_at(0, RDY, 16'h1, "rst_rdy");
        expect_at(0, AEC, 16'h1, "rst_aec");
        expect_at(0, WE, 16'h0, "ph0_we");
        expect_at(1, WE, 16'h1, "wr_we");
        expect_at(1, MA, 16'h1000, "wr_addr");
        expect_at(1, MD, 16'h0077, "wr_data");
        expect_ack(2, 0, 8'h00);
        at(2);
        cpu(1, 0, 16'h1000, 8'h00);
        expect_ack(4, 1, 8'h77);
        at(4);
        cpu(0, 0, 16'h0000, 8'h00);
        bank = 2'b00;
        vic_ao = 14'h1234;
        expect_at(4, RA, 16'h0234, "rom_addr");
        expect_at(5, VD, 16'h00A5, "rom_vic_di");
        at(6);
        bank = 2'b01;
        expect_at(6, MA, 16'h5234, "bank1_addr");
        expect_at(7, VD, 16'h0066, "bank1_vic_di");
        at(8);
        bank = 2'b10;
        vic_ao = 14'h1ABC;
        expect_at(8, RA, 16'h0ABC, "bank2_rom_addr");
        expect_at(9, VD, 16'h0043, "bank2_rom_di");
        at(10);
        bank = 2'b00;
        vic_ao = 14'h2234;
        expect_at(10, MA, 16'h2234, "no_overlay_addr");
        expect_at(11, VD, 16'h0016, "no_overlay_di");
        at(12);
        bank = 2'b01;
        ba_in = 1'b1;
        expect_at(12, RDY, 16'h1, "ba_rdy_pre");
        expect_at(13, RDY, 16'h0, "ba_rdy_fall");
        expect_at(18, AEC, 16'h1, "ba_aec_pre");
        expect_at(19, AEC, 16'h0, "ba_aec_fall");
        at(14);
        cpu(1, 1, 16'hD000, 8'h3C);
        expect_at(14, WE, 16'h0, "warn_we_ph0");
        expect_at(15, WE, 16'h1, "warn_we");
        expect_at(15, MA, 16'hD000, "warn_addr");
        expect_at(15, MD, 16'h003C, "warn_data");
        expect_ack(16, 0, 8'h00);
        at(16);
        cpu(1, 0, 16'hD000, 8'h00);
        at(20);
        vic_ao = 14'h07F8;
        expect_at(21, VD, 16'h0080, "spr_ptr");
        at(21);
        vic_ao = 14'h2000;
        expect_at(21, MA, 16'h6000, "vic_ph1_addr");
        expect_at(21, WE, 16'h0, "vic_ph1_we");
        expect_at(22, VD, 16'h0060, "spr_d0");
        at(22);
        vic_ao = 14'h2001;
        expect_at(23, VD, 16'h0061, "spr_d1");
        at(23);
        vic_ao = 14'h2002;
        expect_at(24, VD, 16'h0062, "spr_d2");
        at(40);
        ba_in = 1'b0;
        expect_at(40, RDY, 16'h0, "rel_rdy_pre");
        expect_at(40, AEC, 16'h0, "rel_aec_pre");
        expect_at(41, RDY, 16'h1, "rel_rdy");
        expect_at(41, AEC, 16'h1, "rel_aec");
        expect_ack(42, 1, 8'h3C);
        at(42);
        cpu(0, 0, 16'h0000, 8'h00);
        at(50);
        ba_in = 1'b1;
        expect_at(56, AEC, 16'h1, "ba2_aec_pre");
        expect_at(57, AEC, 16'h0, "ba2_aec_fall");
        at(58);
        cpu(1, 1, 16'h0400, 8'h99);
        expect_at(59, WE, 16'h0, "vic_wr_blk0");
        expect_at(59, MA, 16'h6002, "vic_wr_addr");
        expect_at(61, WE, 16'h0, "vic_wr_blk1");
        at(62);
        ba_in = 1'b0;
        expect_at(62, AEC, 16'h0, "ba2_aec_low");
        expect_at(63, AEC, 16'h1, "ba2_aec_rel");
        expect_at(63, WE, 16'h1, "pend_wr_we");
        expect_at(63, MA, 16'h0400, "pend_wr_addr");
        expect_ack(64, 0, 8'h00);
        at(64);
        cpu(0, 0, 16'h0000, 8'h00);
        at(70);
        ba_in = 1'b1;
        expect_at(70, RDY, 16'h1, "gl_rdy_pre");
        expect_at(71, RDY, 16'h0, "gl_rdy_low");
        expect_at(72, RDY, 16'h1, "gl_rdy_back");
        expect_at(71, AEC, 16'h1, "gl_aec0");
        expect_at(72, AEC, 16'h1, "gl_aec1");
        expect_at(73, AEC, 16'h1, "gl_aec2");
        at(71);
        ba_in = 1'b0;
        at(80);
        cpu(1, 1, 16'h0600, 8'h55);
        expect_at(81, WE, 16'h0, "drop_req_we");
        at(81);
        cpu(0, 1, 16'h0600, 8'h55);
        at(85);
        cpu(1, 0, 16'h0400, 8'h00);
        ba_in = 1'b1;
        expect_at(86, RDY, 16'h0, "race_rdy");
        expect_at(87, RDY, 16'h1, "race_rdy_back");
        expect_ack(88, 1, 8'h99);
        at(86);
        ba_in = 1'b0;
        at(88);
        cpu(0, 0, 16'h0000, 8'h00);
        at(90);
        cpu(1, 1, 16'h0500, 8'h11);
        at(91);
        check("pre_rst_we", 16'(mem_we), 16'h0001);
        #1 reset = 1'b1;
        #1 check("rst_we", 16'(mem_we), 16'h0000);
        check("rst_ack", 16'(cpu_ack), 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        expect_at(0, RDY, 16'h1, "rst2_rdy");
        expect_at(0, AEC, 16'h1, "rst2_aec");
        expect_at(0, WE, 16'h0, "rst2_ph0_we");
        expect_at(0, ACK, 16'h0, "rst2_ack");
        expect_at(1, WE, 16'h1, "rst2_wr_we");
        expect_at(1, MA, 16'h0500, "rst2_wr_addr");
        expect_ack(2, 0, 8'h00);
        at(2);
        cpu(0, 0, 16'h0000, 8'h00);
        at(5);
        foreach (exp_q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cyc %0d never checked", exp_q[i].name, exp_q[i].at);
        end
        foreach (ack_q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_missing: got none, expected ack at cyc %0d", ack_q[i].at);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
